// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file
// write port. ALU results are queued in a small FIFO; the LSU has priority,
// but ALU starvation is bounded by a consecutive-LSU-grant counter. Writes to
// register x0 are consumed without asserting the write enable.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int ALU_DEPTH  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_valid,
    output logic                           alu_ready,
    input  logic [ADDR_W-1:0]              alu_wa,
    input  logic [DATA_W-1:0]              alu_wd,
    input  logic                           lsu_valid,
    output logic                           lsu_ready,
    input  logic [ADDR_W-1:0]              lsu_wa,
    input  logic [DATA_W-1:0]              lsu_wd,
    output logic                           rf_we,
    output logic [ADDR_W-1:0]              rf_wa,
    output logic [DATA_W-1:0]              rf_wd,
    output logic [$clog2(ALU_DEPTH):0]     alu_count,
    output logic                           busy
);

    localparam int PW = $clog2(ALU_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(ALU_DEPTH);
    localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

    logic [ADDR_W-1:0] fifo_wa [ALU_DEPTH];
    logic [DATA_W-1:0] fifo_wd [ALU_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;

    logic fifo_nonempty;
    logic force_alu;
    logic lsu_go;
    logic alu_pop;
    logic push_store;

    // Handshake and grant decisions, all from registered state so the FIFO
    // never falls through in the cycle an entry is written.
    always_comb begin
        fifo_nonempty = (count != '0);
        alu_ready     = !rst && (count < DEPTH_C);
        force_alu     = (starve_cnt == SMAX_C) && fifo_nonempty;
        lsu_ready     = !rst && !force_alu;
        lsu_go        = lsu_valid && lsu_ready;
        alu_pop       = !rst && !lsu_go && fifo_nonempty;
        // x0 results are accepted but never stored
        push_store    = alu_valid && alu_ready && (alu_wa != '0);
        alu_count     = count;
        busy          = fifo_nonempty || rf_we;
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_store) begin
            fifo_wa[wr_ptr] <= alu_wa;
            fifo_wd[wr_ptr] <= alu_wd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is 2^n)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store)
                wr_ptr <= wr_ptr + PW'(1);
            if (alu_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_store, alu_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Consecutive LSU grants while ALU work is waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (alu_pop || !fifo_nonempty) begin
            starve_cnt <= '0;
        end else if (lsu_go && (starve_cnt != SMAX_C)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Registered write port; address/data hold when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (lsu_go) begin
            rf_we <= (lsu_wa != '0);
            rf_wa <= lsu_wa;
            rf_wd <= lsu_wd;
        end else if (alu_pop) begin
            rf_we <= (fifo_wa[rd_ptr] != '0);
            rf_wa <= fifo_wa[rd_ptr];
            rf_wd <= fifo_wd[rd_ptr];
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [5:0]  alu_wa;
    logic [31:0] alu_wd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [5:0]  lsu_wa;
    logic [31:0] lsu_wd;
    logic        rf_we;
    logic [5:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [2:0]  alu_count;
    logic        busy;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_wa    (lsu_wa),
        .lsu_wd    (lsu_wd),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .alu_count (alu_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // reference model state
    logic [5:0]  m_qwa[$];
    logic [31:0] m_qwd[$];
    int          m_starve = 0;
    logic        m_we  = 1'b0;
    logic [5:0]  m_wa  = '0;
    logic [31:0] m_wd  = '0;

    bit          last_alu_acc;
    int          last_grant;   // 0 none, 1 LSU, 2 ALU
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check ready outputs, advance model, check registers
    task automatic step(input logic r, input logic av, input logic [5:0] awa,
                        input logic [31:0] awd, input logic lv,
                        input logic [5:0] lwa, input logic [31:0] lwd);
        bit ra, rl, lgo, pop;
        int pre;
        rst = r; alu_valid = av; alu_wa = awa; alu_wd = awd;
        lsu_valid = lv; lsu_wa = lwa; lsu_wd = lwd;
        #2;
        pre = m_qwa.size();
        ra  = !r && (pre < 4);
        rl  = !r && !((m_starve == 3) && (pre != 0));
        chk("alu_ready", alu_ready, ra);
        chk("lsu_ready", lsu_ready, rl);
        last_alu_acc = av && ra;
        last_grant   = 0;
        if (r) begin
            m_qwa.delete(); m_qwd.delete();
            m_starve = 0; m_we = 0; m_wa = '0; m_wd = '0;
        end else begin
            lgo = lv && rl;
            pop = !lgo && (pre != 0);
            if (lgo) begin
                m_we = (lwa != 0); m_wa = lwa; m_wd = lwd; last_grant = 1;
            end else if (pop) begin
                m_wa = m_qwa.pop_front(); m_wd = m_qwd.pop_front();
                m_we = (m_wa != 0); last_grant = 2;
            end else begin
                m_we = 0;
            end
            if (pop || pre == 0) m_starve = 0;
            else if (lgo && m_starve < 3) m_starve++;
            if (av && ra && awa != 0) begin
                m_qwa.push_back(awa); m_qwd.push_back(awd);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("rf_we", rf_we, m_we);
        chk("rf_wa", rf_wa, m_wa);
        chk("rf_wd", rf_wd, m_wd);
        chk("alu_count", alu_count, m_qwa.size());
        chk("busy", busy, (m_qwa.size() != 0) || m_we);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit   saw_we;
        int   next_alu;
        int   first_a;
        int   fifth_acc;
        logic r, av, lv;
        logic [5:0] awa, lwa;

        // 1: reset with both producers offering
        step(1, 1, 6'd7, 32'h1, 1, 6'd8, 32'h2);
        step(1, 1, 6'd7, 32'h1, 1, 6'd8, 32'h2);
        chk("t1_we", rf_we, 1'b0);
        chk("t1_count", alu_count, 3'd0);
        chk("t1_busy", busy, 1'b0);

        // 2: single ALU result appears two edges later for one cycle
        step(0, 1, 6'd5, 32'hDEADBEEF, 0, 0, 0);
        chk("t2_we_c1", rf_we, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_we_c2", rf_we, 1'b1);
        chk("t2_wa_c2", rf_wa, 6'd5);
        chk("t2_wd_c2", rf_wd, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_we_c3", rf_we, 1'b0);

        // 3: x0 writes from both sides are consumed silently
        saw_we = 0;
        step(0, 0, 0, 0, 1, 6'd0, 32'h1234);
        saw_we |= rf_we;
        chk("t3_lsu_acc", lsu_ready, 1'b1);
        step(0, 1, 6'd0, 32'h5678, 0, 0, 0);
        saw_we |= rf_we;
        chk("t3_alu_acc", last_alu_acc, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            saw_we |= rf_we;
        end
        chk("t3_no_we", saw_we, 1'b0);
        chk("t3_count", alu_count, 3'd0);

        // 4: fill the FIFO under constant LSU pressure
        next_alu = 0; first_a = -1; fifth_acc = -1;
        for (int i = 0; i < 14; i++) begin
            av = (next_alu < 5);
            step(0, av, 6'(10 + next_alu), 32'hA000 + next_alu, 1, 6'(20 + i), 32'hB000 + i);
            if (av && last_alu_acc) begin
                if (next_alu == 4) fifth_acc = cyc;
                next_alu++;
            end
            if (last_grant == 2 && first_a < 0) first_a = cyc;
            if (next_alu == 4 && fifth_acc < 0)
                chk("t4_full_ready", alu_ready, (alu_count < 3'd4));
        end
        chk("t4_all_accepted", next_alu, 5);
        chk("t4_fifth_after_pop", (fifth_acc > first_a) && (first_a > 0), 1'b1);
        idle(8);

        // 5: simultaneous offers from an empty FIFO
        step(0, 1, 6'd4, 32'h44, 1, 6'd3, 32'h33);
        chk("t5_wa_c1", rf_wa, 6'd3);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t5_wa_c2", rf_wa, 6'd4);
        chk("t5_we_c2", rf_we, 1'b1);
        idle(2);

        // 6: reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(0, 1, 6'(30 + i), 32'hC000 + i, 1, 6'(40 + i), 32'hD000 + i);
        chk("t6_queued", alu_count, 3'd3);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_count", alu_count, 3'd0);
        chk("t6_we", rf_we, 1'b0);
        saw_we = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            saw_we |= rf_we;
        end
        chk("t6_no_we", saw_we, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 59) == 0);
            av  = ($urandom_range(0, 9) < 6);
            lv  = ($urandom_range(0, 9) < 5);
            awa = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            lwa = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            step(r, av, awa, $urandom, lv, lwa, $urandom);
        end
        idle(8);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
